pci_rr_arbiter: RTL and testbench
=================================

PCI_RR_ARBITER -- requirements
Module: pci_rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3, number of requesting masters; legal range 2..8.
REQ-002 Parameter RR_MODE, default 1; 1 = round-robin priority, 0 = fixed priority with index 0 highest.
REQ-003 Parameter GNT_TIMEOUT, default 16; idle clocks a granted master may hold GNT without starting FRAME; legal range 2..255.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Rst  input  1  reset, asynchronous and active-high.
REQ-006 frame  input  1  PCI FRAME#, active-low.
REQ-007 irdy  input  1  PCI IRDY#, active-low.
REQ-008 Req  input  NUM_MASTERS  PCI REQ# per master, active-low.
REQ-009 GNT  output  NUM_MASTERS  PCI GNT# per master, active-low, registered.
REQ-010 owner  output  clog2(NUM_MASTERS)  index of the current or last granted master.
REQ-011 busy  output  1  high while a transaction started by a granted master is in progress.

Function
REQ-012 Bus idle SHALL mean frame=1 and irdy=1, sampled on the same rising edge.
REQ-013 States SHALL be IDLE, GRANT, BUSY and HANDOFF.
REQ-014 IDLE: no GNT asserted; on any Req low, select a winner per REQ-019/020, drive that GNT low next cycle and go to GRANT.
REQ-015 GRANT: frame low goes to BUSY.
REQ-015a GRANT: owner Req high with bus idle goes to HANDOFF.
REQ-015b GRANT: timeout counter reaching GNT_TIMEOUT goes to HANDOFF.
REQ-016 BUSY: busy=1; the owner's GNT SHALL stay low while its Req is low.
REQ-016a BUSY: when the owner's Req is high, the owner's GNT SHALL go high, with the state remaining BUSY until bus idle, then HANDOFF.
REQ-017 HANDOFF: all GNT high for exactly one clock.
REQ-017a HANDOFF: then go to GRANT with a new winner if any Req is low, else IDLE.
REQ-018 At most one GNT bit SHALL be low in any cycle; two different owners SHALL always be separated by at least one all-high cycle.
REQ-019 RR_MODE=1: search starts at (owner+1) mod NUM_MASTERS and takes the first low Req, wrapping past NUM_MASTERS-1 to 0.
REQ-020 RR_MODE=0: the lowest index with Req low wins.
REQ-021 The timeout counter SHALL clear on entry to GRANT and increment each GRANT cycle with the bus idle.
REQ-021a The timeout counter SHALL saturate at GNT_TIMEOUT and be unused in other states.
REQ-022 If the previous owner and others request simultaneously in HANDOFF, the previous owner SHALL only win in RR_MODE=1 when it is the sole requester.
REQ-023 A Req glitch (low then high) before the grant is issued SHALL still produce one grant cycle, which then expires through REQ-015a.
REQ-024 owner SHALL update in the cycle its GNT goes low and hold otherwise.

Reset
REQ-025 On Rst=1, asynchronously: state IDLE, GNT all ones, owner=NUM_MASTERS-1 (so the first round-robin search starts at 0), busy=0, counter=0.
REQ-026 Reset asserted mid-transaction SHALL release all grants immediately, regardless of frame.
REQ-027 After Rst deasserts, the first grant SHALL appear no earlier than the second rising Clk edge.

Structure
REQ-028 State encoding constants, bus-idle definition and the default parameter values SHALL live in the shared package pci_arb_pkg.
REQ-029 Winner selection SHALL be a separate combinational sub-module, pci_arb_prio_sel (inputs Req, owner, RR_MODE; outputs winner index and valid).
REQ-030 Everything else SHALL remain in pci_rr_arbiter.

Verification
REQ-031 Reset; Req=3'b110 held, bus idle -> GNT=3'b110 after 1 clk, owner=0; frame low -> busy=1.
REQ-032 RR_MODE=1, Req=3'b000 continuously, each owner runs a 2-cycle FRAME then releases Req -> grants rotate 0,1,2,0, each separated by one GNT=3'b111 cycle.
REQ-033 RR_MODE=0, same stimulus as REQ-032 -> master 0 re-granted every time; masters 1 and 2 never granted.
REQ-034 Grant master 1, keep frame=1 for 16 clocks -> GNT goes to 3'b111 on clock 17, then HANDOFF, then regrant per priority.
REQ-035 Assert Rst during BUSY with frame=0 -> GNT=3'b111 within the same cycle, owner=2, state IDLE.
REQ-036 NUM_MASTERS=8, only Req[7] and Req[0] low, owner=7 -> next grant goes to 0 (wrap-around), then to 7.

Source files
------------

// File: rtl/pci_arb_pkg.sv
// Shared definitions for the PCI round-robin arbiter: state encoding,
// default parameter values and the bus-idle definition.
package pci_arb_pkg;

  localparam int DEF_NUM_MASTERS = 3;
  localparam int DEF_RR_MODE     = 1;
  localparam int DEF_GNT_TIMEOUT = 16;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_HANDOFF = 2'd3
  } arb_state_t;

  // FRAME# and IRDY# are active-low; the bus is idle when both are deasserted.
  function automatic logic bus_idle(input logic frame, input logic irdy);
    return frame & irdy;
  endfunction

endpackage

// File: rtl/pci_arb_prio_sel.sv
// Combinational winner selection over active-low requests, either rotating
// from the slot after the current owner or fixed with index 0 highest.
module pci_arb_prio_sel
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int RR_MODE     = DEF_RR_MODE,
  localparam int OW         = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] Req,
  input  logic [OW-1:0]          owner,
  output logic [OW-1:0]          winner,
  output logic                   valid
);

  int          idx;
  logic [OW-1:0] slot;

  // valid is high whenever at least one Req bit is low; winner is only
  // meaningful while valid is high and carries no handshake of its own.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    slot   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (RR_MODE != 0) begin
        idx = int'(owner) + i + 1;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      end else begin
        idx = i;
      end
      slot = OW'(idx);
      if (!valid && !Req[slot]) begin
        valid  = 1'b1;
        winner = slot;
      end
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// PCI bus arbiter: issues one active-low GNT at a time, tracks the owner's
// transaction and inserts an all-released cycle between owners.
module pci_rr_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int RR_MODE     = DEF_RR_MODE,
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
  localparam int OW         = $clog2(NUM_MASTERS)
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   frame,
  input  logic                   irdy,
  input  logic [NUM_MASTERS-1:0] Req,
  output logic [NUM_MASTERS-1:0] GNT,
  output logic [OW-1:0]          owner,
  output logic                   busy,
  output arb_state_t             dbg_state
);

  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);
  localparam logic [CNT_W-1:0]       TMO = CNT_W'(GNT_TIMEOUT);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   armed_q;
  logic [OW-1:0]          sel_winner;
  logic                   sel_valid;
  logic                   idle;
  logic                   own_released;

  pci_arb_prio_sel #(
    .NUM_MASTERS(NUM_MASTERS),
    .RR_MODE    (RR_MODE)
  ) u_prio_sel (
    .Req   (Req),
    .owner (owner_q),
    .winner(sel_winner),
    .valid (sel_valid)
  );

  assign idle         = bus_idle(frame, irdy);
  assign own_released = Req[owner_q];

  // armed_q holds off the first grant until one clock after reset release.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '1;
      owner_q <= OW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '1;
        if (armed_q && sel_valid) begin
          state_d = ST_GRANT;
          gnt_d   = ~(ONE << sel_winner);
          owner_d = sel_winner;
        end
      end
      ST_GRANT: begin
        cnt_d = cnt_q;
        if (idle && cnt_q != TMO) cnt_d = cnt_q + 8'd1;
        if (!frame) begin
          state_d = ST_BUSY;
        end else if ((own_released && idle) || cnt_q == TMO) begin
          state_d = ST_HANDOFF;
          gnt_d   = '1;
        end
      end
      ST_BUSY: begin
        // The owner keeps GNT only while it still requests; the state waits
        // for the bus to go idle before handing off.
        if (own_released) begin
          gnt_d = '1;
          if (idle) state_d = ST_HANDOFF;
        end
      end
      ST_HANDOFF: begin
        gnt_d   = '1;
        state_d = ST_IDLE;
        if (sel_valid) begin
          state_d = ST_GRANT;
          gnt_d   = ~(ONE << sel_winner);
          owner_d = sel_winner;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '1;
      end
    endcase
  end

  assign GNT       = gnt_q;
  assign owner     = owner_q;
  assign busy      = (state_q == ST_BUSY);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Scenario bench for pci_rr_arbiter: directed checks plus randomized request
// traffic compared against a transaction-level priority model.
module tb_pci_rr_arbiter;
  import pci_arb_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       frame;
  logic       irdy;
  logic       dut_sel;
  logic [2:0] req3;
  logic [2:0] req_a, req_f, gnt_a, gnt_f, gnt3;
  logic [1:0] owner_a, owner_f, owner3;
  logic       busy_a, busy_f, busy3;
  arb_state_t st_a, st_f, st3;
  logic [7:0] req_w, gnt_w;
  logic [2:0] owner_w;
  logic       busy_w;
  arb_state_t st_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  // dut_sel routes the 3-master stimulus to the round-robin (0) or fixed (1) arbiter.
  assign req_a  = dut_sel ? 3'b111 : req3;
  assign req_f  = dut_sel ? req3 : 3'b111;
  assign gnt3   = dut_sel ? gnt_f : gnt_a;
  assign owner3 = dut_sel ? owner_f : owner_a;
  assign busy3  = dut_sel ? busy_f : busy_a;
  assign st3    = dut_sel ? st_f : st_a;

  pci_rr_arbiter #(.NUM_MASTERS(3), .RR_MODE(1), .GNT_TIMEOUT(16)) dut_rr (
    .Clk(Clk), .Rst(Rst), .frame(frame), .irdy(irdy), .Req(req_a),
    .GNT(gnt_a), .owner(owner_a), .busy(busy_a), .dbg_state(st_a));

  pci_rr_arbiter #(.NUM_MASTERS(3), .RR_MODE(0), .GNT_TIMEOUT(16)) dut_fp (
    .Clk(Clk), .Rst(Rst), .frame(frame), .irdy(irdy), .Req(req_f),
    .GNT(gnt_f), .owner(owner_f), .busy(busy_f), .dbg_state(st_f));

  pci_rr_arbiter #(.NUM_MASTERS(8), .RR_MODE(1), .GNT_TIMEOUT(16)) dut_w8 (
    .Clk(Clk), .Rst(Rst), .frame(frame), .irdy(irdy), .Req(req_w),
    .GNT(gnt_w), .owner(owner_w), .busy(busy_w), .dbg_state(st_w));

  task automatic tick();
    @(negedge Clk);
  endtask

  // Priority model: requesters given as a set of indices (mask bit = wants bus).
  function automatic int model_pick(input logic [2:0] m, input int last, input bit fixed);
    if (fixed) begin
      for (int i = 0; i < 3; i++) if (m[i]) return i;
    end else begin
      for (int k = 1; k <= 3; k++) if (m[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic do_reset();
    Rst = 1'b1; req3 = 3'b111; req_w = 8'hFF; frame = 1'b1; irdy = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int t = 0; t < 4 && idx < 0; t++) begin
      tick();
      for (int i = 0; i < 3; i++) if (gnt3[i] == 1'b0) idx = i;
    end
    n_vec++;
    if (idx < 0) begin
      n_err++;
      $display("FAIL grant_wait: got GNT=%b after 4 clocks, want one GNT low", gnt3);
    end
  endtask

  task automatic test_reset();
    dut_sel = 1'b0;
    Rst = 1'b1; req3 = 3'b111; req_w = 8'hFF; frame = 1'b1; irdy = 1'b1;
    tick();
    n_vec++;
    if (gnt3 !== 3'b111 || owner3 !== 2'd2 || busy3 !== 1'b0 || st3 !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got gnt=%b owner=%0d busy=%b st=%0d, want 111/2/0/0",
               gnt3, owner3, busy3, st3);
    end
    n_vec++;
    if (gnt_w !== 8'hFF || owner_w !== 3'd7) begin
      n_err++;
      $display("FAIL reset_w8: got gnt=%h owner=%0d, want ff/7", gnt_w, owner_w);
    end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_first_grant();
    dut_sel = 1'b0;
    Rst = 1'b1; req3 = 3'b110;
    tick();
    Rst = 1'b0;
    tick();
    n_vec++;
    if (gnt3 !== 3'b111) begin
      n_err++;
      $display("FAIL first_edge_no_grant: got %b, want 111", gnt3);
    end
    tick();
    n_vec++;
    if (gnt3 !== 3'b110) begin
      n_err++;
      $display("FAIL second_edge_grant: got %b, want 110", gnt3);
    end
  endtask

  task automatic test_basic();
    dut_sel = 1'b0;
    do_reset();
    req3 = 3'b110;
    tick();
    n_vec++;
    if (gnt3 !== 3'b110 || owner3 !== 2'd0 || st3 !== ST_GRANT) begin
      n_err++;
      $display("FAIL basic_grant: got gnt=%b owner=%0d st=%0d, want 110/0/1", gnt3, owner3, st3);
    end
    frame = 1'b0;
    tick();
    n_vec++;
    if (busy3 !== 1'b1 || gnt3 !== 3'b110) begin
      n_err++;
      $display("FAIL basic_busy: got busy=%b gnt=%b, want 1/110", busy3, gnt3);
    end
    frame = 1'b1; req3 = 3'b111;
    tick();
    n_vec++;
    if (gnt3 !== 3'b111 || st3 !== ST_HANDOFF || busy3 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_release: got gnt=%b st=%0d busy=%b, want 111/3/0", gnt3, st3, busy3);
    end
    tick();
    n_vec++;
    if (st3 !== ST_IDLE) begin
      n_err++;
      $display("FAIL basic_idle: got st=%0d, want 0", st3);
    end
  endtask

  task automatic test_rotation(input bit fixed);
    logic [2:0] one = 3'b001;
    int exp;
    dut_sel = fixed;
    do_reset();
    req3 = 3'b000;
    for (int r = 0; r < 4; r++) begin
      exp = fixed ? 0 : r % 3;
      tick();
      n_vec++;
      if (gnt3 !== ~(one << exp) || owner3 !== 2'(exp)) begin
        n_err++;
        $display("FAIL rotation%0d_round%0d: got gnt=%b owner=%0d, want %b/%0d",
                 fixed, r, gnt3, owner3, ~(one << exp), exp);
      end
      frame = 1'b0;
      tick();
      tick();
      n_vec++;
      if (busy3 !== 1'b1) begin
        n_err++;
        $display("FAIL rotation%0d_busy%0d: got busy=%b, want 1", fixed, r, busy3);
      end
      frame = 1'b1; req3[exp] = 1'b1;
      tick();
      n_vec++;
      if (gnt3 !== 3'b111) begin
        n_err++;
        $display("FAIL rotation%0d_gap%0d: got gnt=%b, want 111", fixed, r, gnt3);
      end
      req3[exp] = 1'b0;
    end
    req3 = 3'b111;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int held = 0;
    dut_sel = 1'b0;
    do_reset();
    req3 = 3'b101;
    tick();
    n_vec++;
    if (gnt3 !== 3'b101 || owner3 !== 2'd1) begin
      n_err++;
      $display("FAIL timeout_grant: got gnt=%b owner=%0d, want 101/1", gnt3, owner3);
    end
    for (int t = 0; t < 16; t++) begin
      tick();
      if (gnt3 === 3'b101) held++;
    end
    n_vec++;
    if (held != 16) begin
      n_err++;
      $display("FAIL timeout_hold: got %0d granted clocks, want 16", held);
    end
    tick();
    n_vec++;
    if (gnt3 !== 3'b111 || st3 !== ST_HANDOFF) begin
      n_err++;
      $display("FAIL timeout_expire: got gnt=%b st=%0d, want 111/3", gnt3, st3);
    end
    req3 = 3'b100;
    tick();
    n_vec++;
    if (gnt3 !== 3'b110 || owner3 !== 2'd0) begin
      n_err++;
      $display("FAIL timeout_regrant: got gnt=%b owner=%0d, want 110/0", gnt3, owner3);
    end
    req3 = 3'b111;
    tick();
    tick();
  endtask

  task automatic test_glitch();
    dut_sel = 1'b0;
    do_reset();
    req3 = 3'b011;
    tick();
    req3 = 3'b111;
    n_vec++;
    if (gnt3 !== 3'b011 || owner3 !== 2'd2) begin
      n_err++;
      $display("FAIL glitch_grant: got gnt=%b owner=%0d, want 011/2", gnt3, owner3);
    end
    tick();
    n_vec++;
    if (gnt3 !== 3'b111 || st3 !== ST_HANDOFF) begin
      n_err++;
      $display("FAIL glitch_expire: got gnt=%b st=%0d, want 111/3", gnt3, st3);
    end
    tick();
    n_vec++;
    if (st3 !== ST_IDLE) begin
      n_err++;
      $display("FAIL glitch_idle: got st=%0d, want 0", st3);
    end
  endtask

  task automatic test_reset_busy();
    dut_sel = 1'b0;
    do_reset();
    req3 = 3'b110;
    tick();
    frame = 1'b0;
    tick();
    n_vec++;
    if (st3 !== ST_BUSY) begin
      n_err++;
      $display("FAIL rstbusy_pre: got st=%0d, want 2", st3);
    end
    #2;
    Rst = 1'b1;
    #1;
    n_vec++;
    if (gnt3 !== 3'b111 || owner3 !== 2'd2 || st3 !== ST_IDLE || busy3 !== 1'b0) begin
      n_err++;
      $display("FAIL rstbusy_async: got gnt=%b owner=%0d st=%0d busy=%b, want 111/2/0/0",
               gnt3, owner3, st3, busy3);
    end
    frame = 1'b1; req3 = 3'b111;
    tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req_w = 8'b0111_1111;
    tick();
    n_vec++;
    if (gnt_w !== 8'h7F || owner_w !== 3'd7) begin
      n_err++;
      $display("FAIL wrap_first: got gnt=%h owner=%0d, want 7f/7", gnt_w, owner_w);
    end
    req_w = 8'b1111_1110;
    tick();
    req_w = 8'b0111_1110;
    tick();
    n_vec++;
    if (gnt_w !== 8'hFE || owner_w !== 3'd0) begin
      n_err++;
      $display("FAIL wrap_to0: got gnt=%h owner=%0d, want fe/0", gnt_w, owner_w);
    end
    req_w = 8'b0111_1111;
    tick();
    n_vec++;
    if (gnt_w !== 8'hFF) begin
      n_err++;
      $display("FAIL wrap_gap: got gnt=%h, want ff", gnt_w);
    end
    req_w = 8'b0111_1110;
    tick();
    n_vec++;
    if (gnt_w !== 8'h7F || owner_w !== 3'd7) begin
      n_err++;
      $display("FAIL wrap_to7: got gnt=%h owner=%0d, want 7f/7", gnt_w, owner_w);
    end
    req_w = 8'hFF;
    tick();
    tick();
  endtask

  task automatic test_random(input bit fixed, input int rounds);
    logic [2:0] one = 3'b001;
    logic [2:0] mask;
    int last = 2;
    int idx, exp, len, bad;
    dut_sel = fixed;
    do_reset();
    mask = 3'($urandom_range(1, 7));
    req3 = ~mask;
    for (int r = 0; r < rounds; r++) begin
      wait_grant(idx);
      exp = model_pick(mask, last, fixed);
      n_vec++;
      if (idx != exp || owner3 !== 2'(exp)) begin
        n_err++;
        $display("FAIL rand%0d_winner%0d: got idx=%0d owner=%0d, want %0d (mask %b last %0d)",
                 fixed, r, idx, owner3, exp, mask, last);
      end
      if (exp >= 0) last = exp;
      bad = 0;
      if ($urandom_range(0, 1) == 1) begin
        frame = 1'b0;
        len = $urandom_range(1, 4);
        for (int t = 0; t < len; t++) begin
          irdy = 1'($urandom_range(0, 1));
          tick();
          if (busy3 !== 1'b1 || gnt3 !== ~(one << last)) bad++;
        end
        irdy = 1'b1;
        n_vec++;
        if (bad != 0) begin
          n_err++;
          $display("FAIL rand%0d_busy%0d: got %0d bad busy clocks, want 0", fixed, r, bad);
        end
      end
      frame = 1'b1;
      req3[last] = 1'b1;
      tick();
      n_vec++;
      if (gnt3 !== 3'b111) begin
        n_err++;
        $display("FAIL rand%0d_release%0d: got gnt=%b, want 111", fixed, r, gnt3);
      end
      mask = 3'($urandom_range(1, 7));
      req3 = ~mask;
    end
    req3 = 3'b111;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dut_sel = 1'b0;
    Rst = 1'b1; req3 = 3'b111; req_w = 8'hFF; frame = 1'b1; irdy = 1'b1;
    test_reset();
    test_first_grant();
    test_basic();
    test_rotation(1'b0);
    test_rotation(1'b1);
    test_timeout();
    test_glitch();
    test_reset_busy();
    test_wrap();
    test_random(1'b0, 40);
    test_random(1'b1, 40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
